// File: rtl/aes_round_sequencer.sv
// Control sequencer for an iterative AES-128 inverse-cipher datapath: key settle wait,
// initial AddRoundKey, nine full inverse rounds, final round, and the Run/Ready handshake.
module aes_round_sequencer #(
  parameter int unsigned KEY_WAIT      = 12,
  parameter int unsigned MIXCOL_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  output logic [2:0] op_sel_o,
  output logic [3:0] key_idx_o,
  output logic       state_ld_o,
  output logic       out_ld_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       ready_o
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned MIX_W  = 2;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned KEY_W  = 4;
  localparam int unsigned RND_W  = 4;

  localparam logic [OP_W-1:0] OP_HOLD      = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADDKEY_IN = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SHIFT     = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB       = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ADDKEY    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MIX       = OP_W'(5);

  localparam logic [KEY_W-1:0] KEY_LAST    = KEY_W'(10);
  localparam logic [RND_W-1:0] ROUND_FIRST = RND_W'(9);

  typedef enum logic [2:0] {
    S_IDLE, S_KEYWAIT, S_INIT, S_SHIFT, S_SUB, S_ADD, S_MIX, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [MIX_W-1:0]   mix_q, mix_d;
  logic [RND_W-1:0]   round_q, round_d;

  logic [OP_W-1:0]    op_sel_q, op_sel_d;
  logic [KEY_W-1:0]   key_idx_q, key_idx_d;
  logic               state_ld_q, state_ld_d;
  logic               out_ld_q, out_ld_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;

  // Next state, then outputs decoded from the next state so the registered
  // outputs line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    mix_d      = mix_q;
    round_d    = round_q;
    op_sel_d   = OP_HOLD;
    key_idx_d  = '0;
    state_ld_d = 1'b0;
    out_ld_d   = 1'b0;
    busy_d     = 1'b0;
    ready_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        round_d = '0;
        if (run_i) begin
          state_d = S_KEYWAIT;
          wait_d  = WAIT_W'(KEY_WAIT - 1);
          round_d = ROUND_FIRST;
        end
      end
      S_KEYWAIT: begin
        if (wait_q == '0) state_d = S_INIT;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      S_INIT:  state_d = S_SHIFT;
      S_SHIFT: state_d = S_SUB;
      S_SUB:   state_d = S_ADD;
      S_ADD: begin
        // Final round skips InvMixColumns, so round never wraps below zero.
        if (round_q != '0) begin
          state_d = S_MIX;
          mix_d   = MIX_W'(MIXCOL_CYCLES - 1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_MIX: begin
        if (mix_q != '0) begin
          mix_d = mix_q - MIX_W'(1);
        end else begin
          round_d = round_q - RND_W'(1);
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        if (!run_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_KEYWAIT: begin
        key_idx_d = KEY_LAST;
        busy_d    = 1'b1;
      end
      S_INIT: begin
        op_sel_d   = OP_ADDKEY_IN;
        key_idx_d  = KEY_LAST;
        state_ld_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_SHIFT: begin
        op_sel_d   = OP_SHIFT;
        state_ld_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_SUB: begin
        op_sel_d   = OP_SUB;
        state_ld_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_ADD: begin
        op_sel_d   = OP_ADDKEY;
        key_idx_d  = round_d;
        state_ld_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_MIX: begin
        op_sel_d   = OP_MIX;
        state_ld_d = (mix_d == '0);
        busy_d     = 1'b1;
      end
      S_DONE: begin
        ready_d  = 1'b1;
        out_ld_d = (state_q != S_DONE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      mix_q      <= '0;
      round_q    <= '0;
      op_sel_q   <= OP_HOLD;
      key_idx_q  <= '0;
      state_ld_q <= 1'b0;
      out_ld_q   <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      mix_q      <= mix_d;
      round_q    <= round_d;
      op_sel_q   <= op_sel_d;
      key_idx_q  <= key_idx_d;
      state_ld_q <= state_ld_d;
      out_ld_q   <= out_ld_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign op_sel_o   = op_sel_q;
  assign key_idx_o  = key_idx_q;
  assign state_ld_o = state_ld_q;
  assign out_ld_o   = out_ld_q;
  assign round_o    = round_q;
  assign busy_o     = busy_q;
  assign ready_o    = ready_q;

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Control FSM for the iterative AES-128 inverse-cipher datapath. After the cipher key is loaded, it waits for the key schedule to settle. It then runs the initial AddRoundKey, nine full inverse rounds and the final inverse round, driving op-select, round-key index and load strobes into the shared state register and transform units. It owns the top-level Run/Ready handshake.

## Interface
- KEY_WAIT, 12: cycles spent in KEYWAIT after start for the key-expansion output to settle; legal range 1–255.
- MIXCOL_CYCLES, 1: latency of the InvMixColumns unit in cycles; legal range 1–4.

- Clk  in  1  single system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  1  start request, level; sampled only in IDLE.
- op_sel  out  3  datapath operation: 0 HOLD, 1 ADDKEY_IN (Plaintext XOR key), 2 INV_SHIFT, 3 INV_SUB, 4 ADDKEY, 5 INV_MIX.
- key_idx  out  4  round-key select 0–10; the datapath uses keyschedule slice [128*key_idx +: 128].
- state_ld  out  1  load enable for the 128-bit state register.
- out_ld  out  1  one-cycle capture strobe for the Ciphertext register.
- round  out  4  current round number, 9 down to 1 for full rounds, 0 for the final round.
- busy  out  1  high from KEYWAIT through the final ADDKEY, inclusive.
- Ready  out  1  result valid; high throughout DONE.

## Operation
- States: IDLE, KEYWAIT, INIT, SHIFT, SUB, ADD, MIX, DONE.
- All outputs are Moore-decoded from registered state and counters. No combinational path runs from Run to any output.
- IDLE: when Run=1 at a rising edge, go to KEYWAIT, load wait_cnt=KEY_WAIT-1 and round=9.
- KEYWAIT: decrement wait_cnt each cycle. At 0, go to INIT. op_sel=HOLD, key_idx=10.
- INIT: op_sel=ADDKEY_IN, key_idx=10, state_ld=1. Go to SHIFT.
- SHIFT: op_sel=2, state_ld=1. Go to SUB.
- SUB: op_sel=3, state_ld=1. Go to ADD.
- ADD: op_sel=4, key_idx=round, state_ld=1.
  - If round≠0, go to MIX and load mix_cnt=MIXCOL_CYCLES-1.
  - If round=0, go to DONE.
- MIX: op_sel=5. state_ld=1 only when mix_cnt=0.
  - While mix_cnt≠0, decrement it.
  - At 0, decrement round and go to SHIFT.
- DONE: Ready=1, op_sel=HOLD.
  - out_ld=1 only in the first DONE cycle.
  - Stay while Run=1. Go to IDLE on the first edge with Run=0 (4-phase handshake).
- key_idx=0 in IDLE, DONE and MIX. round holds its value outside ADD/MIX transitions and is 0 in IDLE.
- Run changes during KEYWAIT through the final ADD are ignored; the operation always completes.
- Run already low at DONE entry: Ready is high for exactly one cycle.
- round never underflows: the round=0 path exits via ADD→DONE before any decrement.

## Timing
- Reset (Reset=0, asynchronous) forces:
  - state=IDLE and all counters to 0;
  - outputs op_sel=0, key_idx=0, state_ld=0, out_ld=0, round=0, busy=0, Ready=0.
- Reset mid-operation aborts immediately. After release, IDLE waits for Run.
- Latency: with the edge that samples Run as edge 0, Ready rises after edge L, where L = KEY_WAIT + 4 + 9*(3+MIXCOL_CYCLES).
  - Defaults give L = 52.
  - For defaults: INIT follows edge 12, the round-9 SHIFT follows edge 13, and the final SHIFT/SUB/ADD follow edges 49/50/51.
- state_ld is asserted for exactly 1 + 9*4 + 3 = 40 cycles per operation, independent of MIXCOL_CYCLES.
- Back-to-back operations: minimum spacing is L+2 edges, i.e. one DONE cycle plus one IDLE cycle.

## Test plan
- Reset during INIT (edge 13), then release and Run=1 → all outputs are 0 during reset; a fresh run gives Ready after edge 52 of the new sample.
- Defaults, Run held high → Ready=1 after edge 52; out_ld is high only in cycle 52; Ready stays high until Run=0, then IDLE on the next edge.
- Defaults, Run pulsed for 1 cycle → Ready is high for exactly 1 cycle after edge 52; key_idx sequence during ADDKEY_IN/ADDKEY cycles is 10,9,8,…,1,0.
- MIXCOL_CYCLES=3, KEY_WAIT=1 → Ready after edge 1+4+54=59; state_ld count=40; each MIX lasts 3 cycles with state_ld only in the last.
- Run toggled randomly during busy → the op_sel trace is identical to the undisturbed run.
- Compare against the known-answer decryption vector (FIPS-197 C.1 reversed) through the full datapath → the Ciphertext register matches 00112233445566778899aabbccddeeff when out_ld fires.
